// File: rtl/iob_uart16550_ctrl.sv
// iob_uart16550_ctrl
// Wishbone master that initialises a uart16550 core and then moves bytes
// between system-side TX/RX byte streams and the UART's THR/RBR registers.
// After reset it writes LCR (with DLAB set), DLL, DLM, LCR, FCR and IER in that order.
// It then polls LSR and moves at most one byte per poll. When both sides are
// ready, it picks TX or RX in round-robin order.
//
// Optional feature: define IOB_UART16550_CTRL_ERR_EN to add the sticky
// LSR error flags err_o[3:0] = {BI, FE, PE, OE} and the err_clr_i input.
//
// Ports:
//   clk_i, cke_i, rst_i     clock, clock enable (low = hold), sync active-high reset
//   div_i                   baud divisor, latched when an init sequence starts
//   reinit_i                pulse: re-run init at the next decision point
//   init_done_o             high while initialised and servicing streams
//   tx_data_i/valid/ready   TX byte stream (ready is a one-cycle consume pulse)
//   rx_data_o/valid/ready   RX byte stream (valid/ready handshake)
//   wb_*                    Wishbone master towards the UART register port
module iob_uart16550_ctrl #(
   parameter int unsigned WB_ADDR_W = 3,
   parameter logic [7:0]  LCR_VAL   = 8'h03,
   parameter logic [7:0]  FCR_VAL   = 8'h07
) (
   input  logic                 clk_i,
   input  logic                 cke_i,
   input  logic                 rst_i,
   input  logic [15:0]          div_i,
   input  logic                 reinit_i,
   output logic                 init_done_o,
   input  logic [7:0]           tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [7:0]           rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
`ifdef IOB_UART16550_CTRL_ERR_EN
   output logic [3:0]           err_o,
   input  logic                 err_clr_i,
`endif
   output logic [WB_ADDR_W-1:0] wb_adr_o,
   output logic                 wb_sel_o,
   output logic                 wb_we_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic [7:0]           wb_dat_o,
   input  logic                 wb_ack_i,
   input  logic [7:0]           wb_dat_i
);

   localparam logic [WB_ADDR_W-1:0] ADR_RBR = WB_ADDR_W'(0);
   localparam logic [WB_ADDR_W-1:0] ADR_DLM = WB_ADDR_W'(1);
   localparam logic [WB_ADDR_W-1:0] ADR_FCR = WB_ADDR_W'(2);
   localparam logic [WB_ADDR_W-1:0] ADR_LCR = WB_ADDR_W'(3);
   localparam logic [WB_ADDR_W-1:0] ADR_LSR = WB_ADDR_W'(5);

   typedef enum logic [3:0] {
      INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, INIT_IER,
      POLL, DECIDE, RD_RBR, WR_THR
   } state_t;

   typedef enum logic {RR_TX, RR_RX} rr_t;

   state_t               state, state_d, next_on_ack;
   rr_t                  rr_last, rr_d;
   logic                 pend, pend_d;
   logic                 dr, dr_d, thre, thre_d;
   logic [15:0]          div_q, div_d;
   logic                 init_done_d, tx_ready_d, rx_valid_d;
   logic [7:0]           rx_data_d;
   logic                 cyc_d, stb_d, sel_d, we_d;
   logic [WB_ADDR_W-1:0] adr_d;
   logic [7:0]           dat_d;
   logic                 is_wb, req_we;
   logic [WB_ADDR_W-1:0] req_adr;
   logic [7:0]           req_dat;
   logic                 rx_ok, tx_ok;
   logic [3:0]           err_set;

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= INIT_LCR_DLAB;
         rr_last     <= RR_TX;
         pend        <= 1'b0;
         dr          <= 1'b0;
         thre        <= 1'b0;
         div_q       <= '0;
         init_done_o <= 1'b0;
         tx_ready_o  <= 1'b0;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_sel_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
      end else if (cke_i) begin
         state       <= state_d;
         rr_last     <= rr_d;
         pend        <= pend_d;
         dr          <= dr_d;
         thre        <= thre_d;
         div_q       <= div_d;
         init_done_o <= init_done_d;
         tx_ready_o  <= tx_ready_d;
         rx_data_o   <= rx_data_d;
         rx_valid_o  <= rx_valid_d;
         wb_cyc_o    <= cyc_d;
         wb_stb_o    <= stb_d;
         wb_sel_o    <= sel_d;
         wb_we_o     <= we_d;
         wb_adr_o    <= adr_d;
         wb_dat_o    <= dat_d;
      end
   end

   assign rx_ok = dr & ~rx_valid_o;
   assign tx_ok = thre & tx_valid_i;

   // Next state, bus sequencing and output updates
   always_comb begin
      state_d     = state;
      rr_d        = rr_last;
      pend_d      = pend | reinit_i;
      dr_d        = dr;
      thre_d      = thre;
      div_d       = div_q;
      init_done_d = init_done_o;
      tx_ready_d  = 1'b0;
      rx_data_d   = rx_data_o;
      rx_valid_d  = rx_valid_o & ~rx_ready_i;
      cyc_d       = wb_cyc_o;
      stb_d       = wb_stb_o;
      sel_d       = wb_sel_o;
      we_d        = wb_we_o;
      adr_d       = wb_adr_o;
      dat_d       = wb_dat_o;
      err_set     = '0;
      is_wb       = 1'b1;
      req_we      = 1'b0;
      req_adr     = '0;
      req_dat     = '0;
      next_on_ack = state;

      // Register access requested by each bus-owning state
      case (state)
         INIT_LCR_DLAB: begin
            req_we = 1'b1; req_adr = ADR_LCR; req_dat = LCR_VAL | 8'h80;
            next_on_ack = INIT_DLL;
         end
         INIT_DLL: begin
            req_we = 1'b1; req_adr = ADR_RBR; req_dat = div_q[7:0];
            next_on_ack = INIT_DLM;
         end
         INIT_DLM: begin
            req_we = 1'b1; req_adr = ADR_DLM; req_dat = div_q[15:8];
            next_on_ack = INIT_LCR;
         end
         INIT_LCR: begin
            req_we = 1'b1; req_adr = ADR_LCR; req_dat = LCR_VAL & 8'h7F;
            next_on_ack = INIT_FCR;
         end
         INIT_FCR: begin
            req_we = 1'b1; req_adr = ADR_FCR; req_dat = FCR_VAL;
            next_on_ack = INIT_IER;
         end
         INIT_IER: begin
            req_we = 1'b1; req_adr = ADR_DLM; req_dat = 8'h00;
            next_on_ack = POLL;
         end
         POLL: begin
            req_adr = ADR_LSR;
            next_on_ack = DECIDE;
         end
         RD_RBR: begin
            req_adr = ADR_RBR;
            next_on_ack = POLL;
         end
         WR_THR: begin
            req_we = 1'b1; req_adr = ADR_RBR; req_dat = tx_data_i;
            next_on_ack = POLL;
         end
         default: is_wb = 1'b0;
      endcase

      if (is_wb) begin
         // Idle with cyc low: the cycle after an ack is always idle, so this also
         // enforces the one-cycle gap between transactions.
         if (!wb_cyc_o) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            sel_d = 1'b1;
            we_d  = req_we;
            adr_d = req_adr;
            dat_d = req_dat;
            if (state == INIT_LCR_DLAB) div_d = div_i;
         end else if (wb_ack_i) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            sel_d   = 1'b0;
            state_d = next_on_ack;
            case (state)
               INIT_IER: init_done_d = 1'b1;
               POLL: begin
                  dr_d    = wb_dat_i[0];
                  thre_d  = wb_dat_i[5];
                  err_set = wb_dat_i[4:1];
               end
               RD_RBR: begin
                  rx_data_d  = wb_dat_i;
                  rx_valid_d = 1'b1;
                  rr_d       = RR_RX;
               end
               WR_THR: begin
                  tx_ready_d = 1'b1;
                  rr_d       = RR_TX;
               end
               default: ;
            endcase
         end
      end else if (state == DECIDE) begin
         // A reinit pulse arriving in this very cycle is kept for the next decision.
         if (pend) begin
            init_done_d = 1'b0;
            pend_d      = reinit_i;
            state_d     = INIT_LCR_DLAB;
         end else if (rx_ok && tx_ok) begin
            state_d = (rr_last == RR_TX) ? RD_RBR : WR_THR;
         end else if (rx_ok) begin
            state_d = RD_RBR;
         end else if (tx_ok) begin
            state_d = WR_THR;
         end else begin
            state_d = POLL;
         end
      end else begin
         state_d = INIT_LCR_DLAB;
      end
   end

`ifdef IOB_UART16550_CTRL_ERR_EN
   // Sticky LSR error flags; a clear wins over a same-cycle set
   always_ff @(posedge clk_i) begin
      if (rst_i)          err_o <= '0;
      else if (cke_i) begin
         if (err_clr_i)   err_o <= '0;
         else             err_o <= err_o | err_set;
      end
   end
`else
   logic unused_err;
   assign unused_err = ^err_set;
`endif

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// Directed self-checking bench for iob_uart16550_ctrl with a behavioural
// Wishbone slave (programmable ack delay, LSR/RBR read data).
module tb_iob_uart16550_ctrl;

   logic        clk = 1'b0;
   logic        cke_i, rst_i, reinit_i;
   logic [15:0] div_i;
   logic        init_done_o;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i, tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o, rx_ready_i;
   logic [2:0]  wb_adr_o;
   logic        wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_i;
   logic [7:0]  wb_dat_i;
`ifdef IOB_UART16550_CTRL_ERR_EN
   logic [3:0]  err_o;
   logic        err_clr_i;
`endif

   iob_uart16550_ctrl dut (
      .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i), .div_i(div_i),
      .reinit_i(reinit_i), .init_done_o(init_done_o),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
`ifdef IOB_UART16550_CTRL_ERR_EN
      .err_o(err_o), .err_clr_i(err_clr_i),
`endif
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_o(wb_dat_o),
      .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       we;
      logic [2:0] adr;
      logic [7:0] dat;
      logic       done;
   } txn_t;

   txn_t       log_q[$];
   int         lsr_reads = 0;
   int         ack_delay = 2;
   int         wait_cnt  = 0;
   logic [7:0] lsr_val   = 8'h00;
   logic [7:0] rbr_val   = 8'h00;
   int         tx_pulses = 0;
   int         proto_viol = 0;
   int         txr_viol  = 0;
   bit         prev_ack  = 1'b0;
   int         vectors   = 0;
   int         miscompares = 0;

   assign wb_dat_i = (wb_adr_o == 3'd5) ? lsr_val : rbr_val;

   // Wishbone slave: ack after ack_delay cycles, log every non-LSR access
   always @(posedge clk) begin
      if (rst_i) begin
         wb_ack_i <= 1'b0;
         wait_cnt <= 0;
      end else begin
         wb_ack_i <= 1'b0;
         if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (wait_cnt + 1 >= ack_delay) begin
               wb_ack_i <= 1'b1;
               wait_cnt <= 0;
               if (!wb_we_o && wb_adr_o == 3'd5) lsr_reads++;
               else log_q.push_back('{we: wb_we_o, adr: wb_adr_o,
                                      dat: (wb_we_o ? wb_dat_o : wb_dat_i),
                                      done: init_done_o});
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   // Bus protocol and tx_ready monitor
   always @(negedge clk) begin
      if (!rst_i) begin
         if (wb_stb_o != wb_cyc_o || wb_sel_o != wb_cyc_o) proto_viol++;
         if (prev_ack && wb_cyc_o) proto_viol++;
         prev_ack = wb_cyc_o && wb_ack_i;
         if (tx_ready_o) begin
            tx_pulses++;
            if (!init_done_o) txr_viol++;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic we, input logic [2:0] adr, input logic [7:0] dat);
      return {20'd0, we, adr, dat};
   endfunction

   function automatic txn_t log_at(input int idx);
      txn_t e;
      e = '0;
      if (idx < log_q.size()) e = log_q[idx];
      return e;
   endfunction

   // Six init writes starting at log index base, all with init_done low
   task automatic check_init(input int base, input logic [15:0] div);
      logic [2:0] ea[6];
      logic [7:0] ed[6];
      txn_t e;
      ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
      ed = '{8'h83, div[7:0], div[15:8], 8'h03, 8'h07, 8'h00};
      for (int i = 0; i < 6; i++) begin
         e = log_at(base + i);
         check_val($sformatf("init_wr%0d", i), pk(e.we, e.adr, e.dat), pk(1'b1, ea[i], ed[i]));
         check_val($sformatf("init_done_low%0d", i), 32'(e.done), 32'd0);
      end
   endtask

   initial begin
      txn_t e;
      bit   ok, seen_low;
      int   snap;
      cke_i = 1'b1; rst_i = 1'b1; reinit_i = 1'b0; div_i = 16'h001B;
      tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
`ifdef IOB_UART16550_CTRL_ERR_EN
      err_clr_i = 1'b0;
`endif
      repeat (3) @(negedge clk);

      // Reset state
      check_val("rst_cyc", 32'(wb_cyc_o), 32'd0);
      check_val("rst_stb", 32'(wb_stb_o), 32'd0);
      check_val("rst_init_done", 32'(init_done_o), 32'd0);
      check_val("rst_tx_ready", 32'(tx_ready_o), 32'd0);
      check_val("rst_rx_valid", 32'(rx_valid_o), 32'd0);
`ifdef IOB_UART16550_CTRL_ERR_EN
      check_val("rst_err", 32'(err_o), 32'd0);
`endif
      rst_i = 1'b0;
      @(negedge clk);
      check_val("first_stb", 32'(wb_stb_o), 32'd1);
      check_val("first_adr", pk(wb_we_o, wb_adr_o, wb_dat_o), pk(1'b1, 3'd3, 8'h83));

      // Init sequence
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (init_done_o) begin ok = 1'b1; break; end
      end
      check_val("init_done_seen", 32'(ok), 32'd1);
      check_val("init_count", 32'(log_q.size()), 32'd6);
      check_init(0, 16'h001B);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wb_stb_o) begin ok = 1'b1; break; end
      end
      check_val("post_init_lsr", pk(wb_we_o, wb_adr_o, 8'h00) | 32'(ok) << 16, pk(1'b0, 3'd5, 8'h00) | 32'd1 << 16);

      // Single TX byte
      log_q.delete();
      tx_pulses = 0;
      tx_data_i = 8'h41; tx_valid_i = 1'b1; lsr_val = 8'h20;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_ready_o) begin ok = 1'b1; tx_valid_i = 1'b0; break; end
      end
      check_val("tx_ready_seen", 32'(ok), 32'd1);
      snap = lsr_reads;
      repeat (30) @(negedge clk);
      check_val("tx_count", 32'(log_q.size()), 32'd1);
      e = log_at(0);
      check_val("tx_thr_wr", pk(e.we, e.adr, e.dat), pk(1'b1, 3'd0, 8'h41));
      check_val("tx_pulses", 32'(tx_pulses), 32'd1);
      check_val("poll_resume", 32'(lsr_reads > snap), 32'd1);

      // Round-robin with both sides ready
      log_q.delete();
      rbr_val = 8'h33; rx_ready_i = 1'b1; tx_data_i = 8'h10; tx_valid_i = 1'b1;
      lsr_val = 8'h21;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_ready_o) tx_data_i = tx_data_i + 8'd1;
         if (log_q.size() >= 4) break;
      end
      tx_valid_i = 1'b0; lsr_val = 8'h00;
      repeat (30) @(negedge clk);
      check_val("rr_count", 32'(log_q.size()), 32'd4);
      e = log_at(0); check_val("rr0_rx", pk(e.we, e.adr, e.dat), pk(1'b0, 3'd0, 8'h33));
      e = log_at(1); check_val("rr1_tx", pk(e.we, e.adr, e.dat), pk(1'b1, 3'd0, 8'h10));
      e = log_at(2); check_val("rr2_rx", pk(e.we, e.adr, e.dat), pk(1'b0, 3'd0, 8'h33));
      e = log_at(3); check_val("rr3_tx", pk(e.we, e.adr, e.dat), pk(1'b1, 3'd0, 8'h11));
      check_val("rr_rx_data", 32'(rx_data_o), 32'h33);

      // RX back-pressure
      log_q.delete();
      rx_ready_i = 1'b0; rbr_val = 8'h5A; lsr_val = 8'h01;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rx_valid_o) begin ok = 1'b1; break; end
      end
      check_val("rx_valid_seen", 32'(ok), 32'd1);
      check_val("rx_data", 32'(rx_data_o), 32'h5A);
      repeat (60) @(negedge clk);
      check_val("rx_no_reread", 32'(log_q.size()), 32'd1);
      check_val("rx_hold", {23'd0, rx_valid_o, rx_data_o}, {23'd0, 1'b1, 8'h5A});
      rbr_val = 8'h5B; rx_ready_i = 1'b1;
      @(negedge clk);
      check_val("rx_valid_clear", 32'(rx_valid_o), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (log_q.size() >= 2) begin ok = 1'b1; break; end
      end
      e = log_at(1);
      check_val("rx_reread", pk(e.we, e.adr, e.dat) | 32'(ok) << 16, pk(1'b0, 3'd0, 8'h5B) | 32'd1 << 16);
      lsr_val = 8'h00;
      repeat (30) @(negedge clk);

      // Reinit during a slow THR write
      log_q.delete();
      ack_delay = 5; div_i = 16'h1234;
      tx_data_i = 8'h77; tx_valid_i = 1'b1; lsr_val = 8'h20;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wb_stb_o && wb_we_o && wb_adr_o == 3'd0) begin ok = 1'b1; break; end
      end
      check_val("thr_start_seen", 32'(ok), 32'd1);
      reinit_i = 1'b1;
      @(negedge clk);
      reinit_i = 1'b0;
      ok = 1'b0; seen_low = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_ready_o) tx_valid_i = 1'b0;
         if (!init_done_o) seen_low = 1'b1;
         if (seen_low && init_done_o) begin ok = 1'b1; break; end
      end
      check_val("reinit_done", 32'(ok), 32'd1);
      check_val("reinit_count", 32'(log_q.size()), 32'd7);
      e = log_at(0);
      check_val("reinit_thr", pk(e.we, e.adr, e.dat), pk(1'b1, 3'd0, 8'h77));
      check_init(1, 16'h1234);
      ack_delay = 2;
      lsr_val = 8'h00;
      repeat (20) @(negedge clk);

`ifdef IOB_UART16550_CTRL_ERR_EN
      // Sticky error flags
      lsr_val = 8'h0A;
      repeat (40) @(negedge clk);
      check_val("err_set", 32'(err_o), 32'h5);
      lsr_val = 8'h00;
      repeat (40) @(negedge clk);
      check_val("err_sticky", 32'(err_o), 32'h5);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      check_val("err_clr", 32'(err_o), 32'h0);
`endif

      check_val("wb_protocol", 32'(proto_viol), 32'd0);
      check_val("tx_ready_in_init", 32'(txr_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
